// File: rtl/fm_dds_modulator.sv
// FM transmitter DDS: audio scales a deviation word onto the carrier frequency word,
// a dithered phase accumulator drives a quarter-wave sine table into a D-bit offset-binary DAC.
module fm_dds_modulator #(
    parameter int A = 8,
    parameter int L = 12,
    parameter int N = 18,
    parameter int M = 5,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [A-1:0] audio,
    input  logic         audio_valid,
    input  logic [N-1:0] acc_inc,
    input  logic [L-1:0] df_inc,
    input  logic [2:0]   dith_fact,
    input  logic [D-1:0] dac_ena,
    output logic [D-1:0] rf,
    output logic         rf_valid,
    output logic [N-1:0] phase
);

    localparam int          Q    = 2 ** (M - 2);
    localparam logic [15:0] SEED = 16'hACE1;

    if (M < 3) begin : g_bad_m
        $error("fm_dds_modulator: M must be at least 3");
    end

    // Quarter-wave table, sampled at bin centres and offset into the upper half of the DAC range.
    function automatic logic [Q*D-1:0] sine_lut();
        logic [Q*D-1:0] lut;
        real            amp;
        real            v;
        lut = '0;
        amp = (2.0 ** (D - 1)) - 0.5;
        for (int i = 0; i < Q; i++) begin
            v = amp + amp * $sin(2.0 * 3.14159265358979 * (i + 0.5) / (2.0 ** M));
            lut[i*D +: D] = D'($rtoi(v + 0.5));
        end
        return lut;
    endfunction

    localparam logic [Q*D-1:0] LUT = sine_lut();

    typedef enum logic [1:0] {S_OFF, S_FILL, S_RUN} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_cnt;
    logic signed [A-1:0] r_aud;
    logic [N-1:0]       r_acc_s;
    logic [L-1:0]       r_df_s;
    logic [N-1:0]       r_fw;
    logic [N-1:0]       r_phase;
    logic [15:0]        r_lfsr;
    logic [D-1:0]       r_rf;
    logic               r_rf_valid;

    logic               w_shadow_ld;
    logic               w_lfsr_adv;
    logic               w_clr;
    logic signed [A+L-1:0] w_prod;
    logic [N-1:0]       w_offset;
    logic [6:0]         w_dmask;
    logic [6:0]         w_dither;
    logic [N:0]         w_sum;
    logic [M-1:0]       w_p;
    logic [M-3:0]       w_addr;
    logic [D-1:0]       w_mag;
    logic [D-1:0]       w_sine;
    logic               w_fb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_next == S_FILL && r_state != S_FILL)
                r_cnt <= 2'd2;
            else if (r_state == S_FILL)
                r_cnt <= r_cnt - 2'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_OFF:   if (ena) w_next = S_FILL;
            S_FILL:  if (!ena) w_next = S_OFF;
                     else if (r_cnt == 2'd0) w_next = S_RUN;
            S_RUN:   if (!ena) w_next = S_OFF;
            default: w_next = S_OFF;
        endcase
    end

    // Shadows track the inputs freely until RUN; afterwards they only move on a phase wrap
    // so a frequency change never lands mid-cycle of the carrier.
    always_comb begin
        w_shadow_ld = 1'b1;
        w_lfsr_adv  = 1'b0;
        w_clr       = 1'b0;
        if (r_state == S_RUN) begin
            w_shadow_ld = w_sum[N];
            w_lfsr_adv  = 1'b1;
        end
        if (r_state == S_OFF || w_next == S_OFF)
            w_clr = 1'b1;
    end

    assign w_prod   = r_aud * $signed({1'b0, r_df_s});
    assign w_offset = N'(w_prod >>> (A - 1));
    assign w_dmask  = 7'((8'd1 << dith_fact) - 8'd1);
    assign w_dither = r_lfsr[6:0] & w_dmask;
    assign w_sum    = {1'b0, r_phase} + {1'b0, r_fw} + (N+1)'(w_dither);
    assign w_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    assign w_p      = r_phase[N-1:N-M];
    assign w_addr   = w_p[M-2] ? ~w_p[M-3:0] : w_p[M-3:0];
    assign w_mag    = LUT[w_addr*D +: D];
    assign w_sine   = w_p[M-1] ? ~w_mag : w_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aud      <= '0;
            r_acc_s    <= '0;
            r_df_s     <= '0;
            r_fw       <= '0;
            r_phase    <= '0;
            r_lfsr     <= SEED;
            r_rf       <= '0;
            r_rf_valid <= 1'b0;
        end else begin
            if (audio_valid)
                r_aud <= audio;
            if (w_shadow_ld) begin
                r_acc_s <= acc_inc;
                r_df_s  <= df_inc;
            end
            r_fw <= r_acc_s + w_offset;
            if (w_clr) begin
                r_phase <= '0;
                r_lfsr  <= SEED;
            end else begin
                r_phase <= w_sum[N-1:0];
                if (w_lfsr_adv)
                    r_lfsr <= {w_fb, r_lfsr[15:1]};
            end
            r_rf       <= (w_next == S_RUN) ? (w_sine & dac_ena) : '0;
            r_rf_valid <= (w_next == S_RUN);
        end
    end

    assign rf       = r_rf;
    assign rf_valid = r_rf_valid;
    assign phase    = r_phase;

endmodule

// File: tb/tb_fm_dds_modulator.sv
// Directed bench for fm_dds_modulator: carrier sine shape, deviation latency,
// wrap-synchronous frequency change, dither sequence, reset and FILL abort.
module tb_fm_dds_modulator;

    localparam int A = 8, L = 12, N = 18, M = 5, D = 4;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [A-1:0] audio;
    logic         audio_valid;
    logic [N-1:0] acc_inc;
    logic [L-1:0] df_inc;
    logic [2:0]   dith_fact;
    logic [D-1:0] dac_ena;
    logic [D-1:0] rf;
    logic         rf_valid;
    logic [N-1:0] phase;

    int checks = 0;
    int errors = 0;

    // round(7.5 + 7.5*sin(2*pi*(p+0.5)/32)) for p = 0..31
    int sine_tbl [0:31] = '{8, 10, 11, 12, 13, 14, 15, 15,
                            15, 15, 14, 13, 12, 11, 10, 8,
                            7, 5, 4, 3, 2, 1, 0, 0,
                            0, 0, 1, 2, 3, 4, 5, 7};

    fm_dds_modulator #(.A(A), .L(L), .N(N), .M(M), .D(D)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .audio(audio), .audio_valid(audio_valid),
        .acc_inc(acc_inc), .df_inc(df_inc), .dith_fact(dith_fact), .dac_ena(dac_ena),
        .rf(rf), .rf_valid(rf_valid), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        int n;
        ena = 1'b0;
        tick();
        ena = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rf_valid && n < 10);
        checks++;
        if (rf_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_run: rf_valid=%b after %0d cycles, required 1", rf_valid, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; audio = '0; audio_valid = 1'b0;
        acc_inc = 18'd8192; df_inc = '0; dith_fact = 3'd0; dac_ena = 4'hF;
        #12;
        checks++;
        if (rf !== 4'd0 || rf_valid !== 1'b0 || phase !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: rf=%0d rf_valid=%b phase=%0d, required 0/0/0", rf, rf_valid, phase);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rf_valid !== 1'b0 || phase !== 18'd0) begin
            errors++;
            $display("FAIL idle_off: rf_valid=%b phase=%0d, required 0/0", rf_valid, phase);
        end
    endtask

    task automatic test_carrier();
        int prev, p;
        acc_inc = 18'd8192; df_inc = '0; dith_fact = 3'd0; dac_ena = 4'hF;
        start_run();
        prev = int'(phase[N-1:N-M]);
        for (int i = 0; i < 33; i++) begin
            tick();
            p = int'(phase[N-1:N-M]);
            checks++;
            if (p !== (prev + 1) % 32) begin
                errors++;
                $display("FAIL carrier_step: p=%0d, required %0d", p, (prev + 1) % 32);
            end
            checks++;
            if (int'(rf) !== sine_tbl[prev]) begin
                errors++;
                $display("FAIL carrier_sine: p=%0d rf=%0d, required %0d", prev, rf, sine_tbl[prev]);
            end
            prev = p;
        end
    endtask

    task automatic dev_step(input logic [A-1:0] smp, input int old_step, input int new_step);
        logic [N-1:0] prev, delta;
        int exp_step [0:2];
        exp_step = '{old_step, old_step, new_step};
        audio = smp; audio_valid = 1'b1;
        for (int e = 0; e < 3; e++) begin
            prev = phase;
            tick();
            audio_valid = 1'b0;
            delta = phase - prev;
            checks++;
            if (int'(delta) !== exp_step[e]) begin
                errors++;
                $display("FAIL deviation_step%0d: audio=%h delta=%0d, required %0d", e, smp, delta, exp_step[e]);
            end
        end
        prev = phase;
        tick();
        checks++;
        if (int'(rf) !== sine_tbl[prev[N-1:N-M]]) begin
            errors++;
            $display("FAIL deviation_rf: rf=%0d, required %0d", rf, sine_tbl[prev[N-1:N-M]]);
        end
    endtask

    task automatic test_deviation();
        df_inc = 12'd128;
        start_run();
        dev_step(8'h7F, 8192, 8192 + 127);
        dev_step(8'h80, 8192 + 127, 8192 - 128);
    endtask

    task automatic test_acc_change();
        logic [N-1:0] prev, delta;
        int stage, exp;
        audio = 8'h00; audio_valid = 1'b1;
        tick();
        audio_valid = 1'b0;
        tick(); tick(); tick();
        acc_inc = 18'd16384;
        stage = 0;
        for (int i = 0; i < 40; i++) begin
            prev = phase;
            tick();
            delta = phase - prev;
            exp = (stage == 2) ? 16384 : 8192;
            checks++;
            if (int'(delta) !== exp) begin
                errors++;
                $display("FAIL acc_change: stage=%0d delta=%0d, required %0d", stage, delta, exp);
            end
            if (stage == 1) stage = 2;
            else if (stage == 0 && phase < prev) stage = 1;
        end
        checks++;
        if (stage !== 2) begin
            errors++;
            $display("FAIL acc_change_wrap: stage=%0d, required 2", stage);
        end
    endtask

    task automatic test_dither();
        logic [N-1:0] prev, delta;
        logic [15:0]  lf;
        acc_inc = '0; df_inc = '0; dith_fact = 3'd3; dac_ena = 4'b0011;
        start_run();
        lf = 16'hACE1;
        for (int i = 0; i < 12; i++) begin
            prev = phase;
            tick();
            delta = phase - prev;
            checks++;
            if (delta !== N'(lf[2:0])) begin
                errors++;
                $display("FAIL dither_step%0d: delta=%0d, required %0d", i, delta, lf[2:0]);
            end
            checks++;
            if (rf[3:2] !== 2'b00) begin
                errors++;
                $display("FAIL dac_mask: rf=%b, required 00xx", rf);
            end
            lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
        end
    endtask

    task automatic test_reset_run();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (rf !== 4'd0 || rf_valid !== 1'b0 || phase !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_run: rf=%0d rf_valid=%b phase=%0d, required 0/0/0", rf, rf_valid, phase);
        end
        acc_inc = 18'd8192; dith_fact = 3'd0; dac_ena = 4'hF; ena = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (rf_valid !== (e == 4)) begin
                errors++;
                $display("FAIL reset_release_edge%0d: rf_valid=%b, required %b", e, rf_valid, e == 4);
            end
        end
    endtask

    task automatic test_fill_abort();
        ena = 1'b0;
        tick();
        ena = 1'b1;
        tick();
        tick();
        checks++;
        if (phase !== 18'd8192 || rf_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_progress: phase=%0d rf_valid=%b, required 8192/0", phase, rf_valid);
        end
        ena = 1'b0;
        tick();
        checks++;
        if (phase !== 18'd0 || rf_valid !== 1'b0 || rf !== 4'd0) begin
            errors++;
            $display("FAIL fill_abort: phase=%0d rf_valid=%b rf=%0d, required 0/0/0", phase, rf_valid, rf);
        end
        tick();
        ena = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (rf_valid !== (e == 4)) begin
                errors++;
                $display("FAIL refill_edge%0d: rf_valid=%b, required %b", e, rf_valid, e == 4);
            end
            if (e <= 2) begin
                checks++;
                if (phase !== N'((e - 1) * 8192)) begin
                    errors++;
                    $display("FAIL refill_phase%0d: phase=%0d, required %0d", e, phase, (e - 1) * 8192);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_carrier();
        test_deviation();
        test_acc_change();
        test_dither();
        test_reset_run();
        test_fill_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fm_dds_modulator.md
FM_DDS_MODULATOR -- requirements
Module: fm_dds_modulator

Interface
REQ-001 The block SHALL have parameter A, default 8: audio sample width, two's complement.
REQ-002 The block SHALL have parameter L, default 12: frequency-deviation increment width, unsigned.
REQ-003 The block SHALL have parameter N, default 18: phase accumulator width.
REQ-004 The block SHALL have parameter M, default 5: phase bits into the sine table; M SHALL be at least 3.
REQ-005 The block SHALL have parameter D, default 4: DAC output width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port ena, input, 1 bit: transmitter enable.
REQ-009 The block SHALL have port audio, input, A bits: signed audio sample, synchronous to clk.
REQ-010 The block SHALL have port audio_valid, input, 1 bit: one-cycle strobe marking a new audio sample.
REQ-011 The block SHALL have port acc_inc, input, N bits: carrier frequency word.
REQ-012 The block SHALL have port df_inc, input, L bits: deviation increment.
REQ-013 The block SHALL have port dith_fact, input, 3 bits: number of phase-dither bits, 0 to 7.
REQ-014 The block SHALL have port dac_ena, input, D bits: per-bit DAC output enable.
REQ-015 The block SHALL have port rf, output, D bits: offset-binary RF sample.
REQ-016 The block SHALL have port rf_valid, output, 1 bit: high while rf carries modulated signal.
REQ-017 The block SHALL have port phase, output, N bits: current phase accumulator value, for debug.

Function
REQ-018 Audio register aud_q SHALL load audio on each clk edge where audio_valid=1, and SHALL hold its value otherwise.
REQ-019 Shadow registers acc_s/df_s SHALL load acc_inc/df_inc every cycle in states OFF and FILL; in RUN they SHALL load only in the cycle the phase accumulator carries out (wraps past 2^N).
REQ-020 The frequency offset SHALL be computed as the signed full product aud_q*df_s (A+L bits), arithmetic-shifted right by A-1 and sign-extended to N bits.
REQ-021 Stage 1 SHALL register the frequency word fw_q = acc_s + offset, modulo 2^N.
REQ-022 Dither: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL advance every cycle in RUN; dither = lfsr[dith_fact-1:0], zero-extended, and dither SHALL be 0 when dith_fact=0.
REQ-023 Stage 2 SHALL update phase <= phase + fw_q + dither, modulo 2^N; carry-out SHALL be the wrap indication.
REQ-024 Stage 3 SHALL generate the sine from p = phase[N-1:N-M] using quarter-wave symmetry (M-2-bit address table); the value SHALL be round(2^(D-1)-0.5 + (2^(D-1)-0.5)*sin(2*pi*(p+0.5)/2^M)), registered and ANDed with dac_ena.
REQ-025 Latency: audio captured at edge k SHALL affect fw_q at k+1, phase at k+2, and rf at k+3.
REQ-026 The FSM SHALL have states OFF, FILL, and RUN.
REQ-027 In OFF: phase=0, LFSR=seed, rf=0, rf_valid=0; OFF SHALL go to FILL when ena=1.
REQ-028 FILL SHALL last exactly 3 cycles (pipeline fill, counter 2 to 0), with rf=0 and rf_valid=0, and SHALL then go to RUN.
REQ-029 In RUN: rf_valid=1.
REQ-030 In any state, ena=0 SHALL force OFF at the next edge, with rf=0, rf_valid=0 and phase=0 at that edge (abort mid-FILL included).
REQ-031 When wrap and an acc_inc change occur in the same cycle, the new value SHALL be captured; fw_q SHALL use it from the following cycle.
REQ-032 All arithmetic SHALL wrap silently; no saturation.

Reset
REQ-033 rst_n=0 SHALL asynchronously set state=OFF, aud_q=0, acc_s=0, df_s=0, fw_q=0, phase=0, LFSR=16'hACE1, rf=0 and rf_valid=0.
REQ-034 Release of rst_n SHALL be taken synchronously; the first FSM transition SHALL occur at least one edge after release.

Verification
REQ-035 Reset mid-RUN -> rf=0, rf_valid=0 and phase=0 immediately (before the next edge); after release with ena=1, rf_valid rises on the 4th edge.
REQ-036 N=18, M=5, D=4; acc_inc=8192, df_inc=0, dith_fact=0 -> p advances by 1 per cycle; rf=8 at p=0, rf=15 at p=7, rf=7 at p=16, rf=0 at p=23; period is 32 cycles.
REQ-037 df_inc=128, audio=0x7F valid -> fw_q=acc_inc+127 one edge after capture; audio=0x80 -> fw_q=acc_inc-128; rf spacing changes from edge k+3.
REQ-038 acc_inc changed from 8192 to 16384 mid-period in RUN -> phase step stays 8192 until the wrap cycle, then becomes 16384.
REQ-039 dith_fact=3, acc_inc=0 -> phase increments by 0 to 7 per cycle, matching the LFSR low 3 bits from seed 16'hACE1; dac_ena=4'b0011 -> rf[3:2]=0 always.
REQ-040 ena dropped during FILL -> OFF next edge; rf_valid never asserts; re-raising ena restarts the 3-cycle FILL with phase=0.
